// File: rtl/cmp_sched_pkg.sv
// Shared types and sizing helpers for the time-multiplexed compare scheduler.
package cmp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit width able to index n items, never less than one bit.
  function automatic int min1_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;
  localparam int ID_W      = min1_clog2(DEF_NREQ);
  localparam int CNT_W     = min1_clog2(DEF_WIDTH);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
  import cmp_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = min1_clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && req[(int'(ptr) + off) % NREQ]) begin
        found = 1'b1;
        gnt[(int'(ptr) + off) % NREQ] = 1'b1;
        idx = IW'((int'(ptr) + off) % NREQ);
      end
    end
  end

endmodule

// File: rtl/cmp_scheduler.sv
// One serial MSB-first magnitude comparator shared round-robin among NREQ requesters.
module cmp_scheduler
  import cmp_sched_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NREQ     = 4,
  localparam int ID_BITS  = min1_clog2(NREQ),
  localparam int CNT_BITS = min1_clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [ID_BITS-1:0]    done_id,
  output logic                  eq,
  output logic                  gt,
  output logic                  lt
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    sa_q, sa_d;
  logic [WIDTH-1:0]    sb_q, sb_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [ID_BITS-1:0]  id_q, id_d;
  logic [ID_BITS-1:0]  rr_q, rr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [ID_BITS-1:0]  done_id_q, done_id_d;
  logic                eq_q, eq_d;
  logic                gt_q, gt_d;
  logic                lt_q, lt_d;

  logic [NREQ-1:0]     arb_gnt;
  logic [ID_BITS-1:0]  arb_idx;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req (req),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    rr_d      = rr_q;
    gnt_d     = '0;
    done_id_d = done_id_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          sa_d    = op_a[int'(arb_idx)*WIDTH +: WIDTH];
          sb_d    = op_b[int'(arb_idx)*WIDTH +: WIDTH];
          id_d    = arb_idx;
          gnt_d   = arb_gnt;
          cnt_d   = '0;
          rr_d    = (arb_idx == ID_BITS'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d = CMP;
        end
      end

      // The first differing bit from the MSB decides the result; equal bits just shift.
      CMP: begin
        if (sa_q[WIDTH-1] != sb_q[WIDTH-1]) begin
          gt_d      = sa_q[WIDTH-1];
          lt_d      = sb_q[WIDTH-1];
          eq_d      = 1'b0;
          done_id_d = id_q;
          state_d   = DONE;
        end else if (cnt_q == CNT_BITS'(WIDTH - 1)) begin
          eq_d      = 1'b1;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          done_id_d = id_q;
          state_d   = DONE;
        end else begin
          sa_d  = sa_q << 1;
          sb_d  = sb_q << 1;
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      rr_q      <= '0;
      gnt_q     <= '0;
      done_id_q <= '0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      done_id_q <= done_id_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q == CMP) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign done_id = done_id_q;
  assign eq      = eq_q;
  assign gt      = gt_q;
  assign lt      = lt_q;

endmodule

// File: tb/tb_cmp_scheduler.sv
// Self-checking bench: directed cases plus random traffic against a behavioural model.
module tb_cmp_scheduler;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a, op_b;
  logic [N-1:0]   gnt;
  logic           busy, done, eq, gt, lt;
  logic [1:0]     done_id;

  logic [0:0]     req1, op_a1, op_b1, gnt1, done_id1;
  logic           busy1, done1, eq1, gt1, lt1;

  int checks   = 0;
  int fails    = 0;
  int model_rr = 0;

  always #5 clk = ~clk;

  cmp_scheduler #(.WIDTH(W), .NREQ(N)) dut (
    .clk (clk), .rst_n (rst_n), .req (req), .op_a (op_a), .op_b (op_b),
    .gnt (gnt), .busy (busy), .done (done), .done_id (done_id),
    .eq (eq), .gt (gt), .lt (lt)
  );

  cmp_scheduler #(.WIDTH(1), .NREQ(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .req (req1), .op_a (op_a1), .op_b (op_b1),
    .gnt (gnt1), .busy (busy1), .done (done1), .done_id (done_id1),
    .eq (eq1), .gt (gt1), .lt (lt1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pickWinner(input logic [N-1:0] r, input int ptr);
    for (int off = 0; off < N; off++)
      if (r[(ptr + off) % N]) return (ptr + off) % N;
    return 0;
  endfunction

  // Starts at a negedge with the DUT idle; returns at the negedge after DONE (idle again).
  task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] a,
                               input logic [N*W-1:0] b, input bit hold);
    int win, lat, cycles, busy_cycles;
    logic [W-1:0] ea, eb, diff;
    req  = r;
    op_a = a;
    op_b = b;
    win      = pickWinner(r, model_rr);
    model_rr = (win + 1) % N;
    ea   = a[win*W +: W];
    eb   = b[win*W +: W];
    diff = ea ^ eb;
    lat  = (diff == 0) ? W : W - $clog2(int'(diff) + 1) + 1;
    @(negedge clk);
    checkOutput("gnt_onehot", 32'(gnt), 32'(1 << win));
    checkOutput("busy_c1", 32'(busy), 32'd1);
    if (!hold) begin
      req  = '0;
      op_a = (N*W)'($urandom);
      op_b = (N*W)'($urandom);
    end
    cycles      = 0;
    busy_cycles = int'(busy);
    while (!done && cycles < W + 2) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cycles++;
      checkOutput("gnt_low", 32'(gnt), 32'd0);
    end
    checkOutput("latency", 32'(cycles), 32'(lat));
    checkOutput("busy_cycles", 32'(busy_cycles), 32'(lat + 1));
    checkOutput("done_id", 32'(done_id), 32'(win));
    checkOutput("eq", 32'(eq), 32'(ea == eb));
    checkOutput("gt", 32'(gt), 32'(ea > eb));
    checkOutput("lt", 32'(lt), 32'(ea < eb));
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd0);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("gt_hold", 32'(gt), 32'(ea > eb));
  endtask

  task automatic runSingle(input logic a, input logic b);
    req1  = 1'b1;
    op_a1 = a;
    op_b1 = b;
    @(negedge clk);
    checkOutput("w1_gnt", 32'(gnt1), 32'd1);
    checkOutput("w1_busy", 32'(busy1), 32'd1);
    req1 = 1'b0;
    @(negedge clk);
    checkOutput("w1_done", 32'(done1), 32'd1);
    checkOutput("w1_eq", 32'(eq1), 32'(a == b));
    checkOutput("w1_gt", 32'(gt1), 32'(a > b));
    checkOutput("w1_lt", 32'(lt1), 32'(a < b));
    checkOutput("w1_done_id", 32'(done_id1), 32'd0);
    @(negedge clk);
    checkOutput("w1_done_drop", 32'(done1), 32'd0);
    checkOutput("w1_idle", 32'(busy1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N*W-1:0] ha, hb, ra, rb;
    logic [N-1:0]   rr;
    bit             saw_done;

    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    req1  = '0;
    op_a1 = '0;
    op_b1 = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_res", 32'({eq, gt, lt}), 32'd0);
    checkOutput("rst_done_id", 32'(done_id), 32'd0);
    checkOutput("rst_w1", 32'({gnt1, busy1, done1, eq1, gt1, lt1}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(4'b0001, 32'h000000A5, 32'h000000A5, 1'b0);
    applyStimulus(4'b0010, 32'h00008000, 32'h00007F00, 1'b0);
    applyStimulus(4'b0100, 32'h00100000, 32'h00110000, 1'b0);

    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_rr = 0;
    @(negedge clk);

    ha = 32'h409C215A;
    hb = 32'h409D01A5;
    for (int t = 0; t < 5; t++) begin
      applyStimulus(4'b1111, ha, hb, t < 4);
      checkOutput("rr_order", 32'(done_id), 32'(t % N));
    end

    req  = 4'b0001;
    op_a = 32'h00000000;
    op_b = 32'h000000FF;
    @(negedge clk);
    checkOutput("abort_gnt", 32'(gnt), 32'd1);
    #1 rst_n = 1'b0;
    req = '0;
    #2 rst_n = 1'b1;
    model_rr = 0;
    saw_done = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_res", 32'({eq, gt, lt}), 32'd0);
    checkOutput("abort_done_id", 32'(done_id), 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      saw_done = saw_done | done;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 32'(saw_done), 32'd0);
    applyStimulus(4'b1111, 32'h01020304, 32'h01020305, 1'b0);
    checkOutput("abort_restart", 32'(done_id), 32'd0);

    for (int t = 0; t < 40; t++) begin
      rr = N'($urandom_range(1, (1 << N) - 1));
      ra = (N*W)'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (32'd1 << $urandom_range(0, N*W - 1));
        default: rb = (N*W)'($urandom);
      endcase
      applyStimulus(rr, ra, rb, 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    runSingle(1'b1, 1'b0);
    runSingle(1'b1, 1'b1);
    runSingle(1'b0, 1'b1);
    runSingle(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cmp_scheduler.md
Name: cmp_scheduler

Overview:
Shares one serial magnitude-compare engine among NREQ requesters. Each requester presents a pair of WIDTH-bit operands. A round-robin arbiter grants the engine to one requester at a time. The engine walks the operands MSB-first, one bit pair per cycle, and stops at the first differing bit. It then reports eq/gt/lt and the ID of the served requester, which lets the comparator datapath be time-multiplexed instead of replicated per requester.

Parameters:
WIDTH, 8, operand width in bits (>=1)
NREQ, 4, number of requesters (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request level
op_a  input  NREQ*WIDTH  flattened A operands; slice i = op_a[i*WIDTH +: WIDTH]
op_b  input  NREQ*WIDTH  flattened B operands, same packing
gnt  output  NREQ  one-hot grant, registered, high exactly one cycle per transaction
busy  output  1  high in CMP and DONE states
done  output  1  one-cycle result-valid pulse
done_id  output  max(1,$clog2(NREQ))  index of the requester whose result is on eq/gt/lt
eq  output  1  A == B
gt  output  1  A > B (unsigned)
lt  output  1  A < B (unsigned)

Behaviour:
- Reset (async assert, sync release): state=IDLE; gnt, busy, done, done_id, eq, gt, lt, bit counter and shift registers all 0; rr pointer=0.
- States: IDLE, CMP, DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set req bit searching upward from the rr pointer, wrapping modulo NREQ.
  - At that edge: latch op_a/op_b of the winner into shift registers sa/sb; latch the winner into id_q; set gnt to one-hot(winner); set bit counter=0; go to CMP.
  - rr pointer <= (winner+1) mod NREQ.
- CMP (gnt is high only in the first CMP cycle):
  - Each cycle compare sa[WIDTH-1] with sb[WIDTH-1].
  - If they differ: gt<=sa MSB, lt<=sb MSB, eq<=0; go to DONE.
  - If they match and counter==WIDTH-1: eq<=1, gt<=0, lt<=0; go to DONE.
  - If they match otherwise: shift sa and sb left by 1, counter+1, stay in CMP.
- DONE: done=1 and done_id=id_q for this one cycle; next state is IDLE.
- eq/gt/lt/done_id are registered and hold until the next DONE. Exactly one of eq/gt/lt is 1 after the first completion.
- Latency: let c1 be the gnt cycle and k the index (from MSB, 0-based) of the first differing bit.
  - done is high in cycle c1+k+1.
  - For equal operands, done is high in cycle c1+WIDTH.
  - Minimum turnaround from one grant to the next is k+3 cycles.
- Requester rules:
  - Operands must be valid whenever req is high; they are sampled only at the grant edge.
  - The requester drops req no later than the DONE cycle. A req still high when the scheduler re-enters IDLE counts as a new request.
- Requests arriving during CMP/DONE are ignored until IDLE; no queueing.
- Simultaneous requests are resolved by the rr pointer only. Every active requester is served within NREQ transactions.
- Operand changes after the grant edge have no effect on the in-flight comparison.
- WIDTH=1: CMP lasts exactly 1 cycle.
- Reset mid-operation aborts the transaction: no done pulse, results cleared to 0, rr pointer back to 0.

Decomposition:
- Package cmp_sched_pkg holds:
  - the state enum (IDLE/CMP/DONE);
  - localparams ID_W = max(1,$clog2(NREQ)) and CNT_W = max(1,$clog2(WIDTH)).
- Sub-module rr_arbiter (params NREQ): inputs req and ptr; outputs a one-hot grant and a binary index. It is purely combinational and is registered by the parent.

Test Plan:
- WIDTH=8, NREQ=4; req=0001, A=0xA5, B=0xA5 -> gnt=0001 in c1; done at c1+8 with eq=1, gt=0, lt=0, done_id=0.
- req=0010, A=0x80, B=0x7F -> MSB mismatch, done at c1+1 with gt=1, done_id=1; busy high for exactly 2 cycles.
- req=0100, A=0x10, B=0x11 -> LSB mismatch, done at c1+8 with lt=1, done_id=2.
- req=1111 held continuously, distinct operands per requester -> grant order 0,1,2,3,0, with done_id matching each grant.
- req=0001, A=0x00, B=0xFF, rst_n pulsed low in the 1st CMP cycle -> no done; outputs 0; state IDLE; next grant order restarts from requester 0.
- WIDTH=1, NREQ=1; A=1, B=0 -> gnt in c1, done at c1+1 with gt=1; A=B=1 -> eq=1.
